// File: rtl/lsu_mem_ctrl_pkg.sv
// lsu_mem_ctrl_pkg: shared size codes and FSM state encoding for the load/store front-end
package lsu_mem_ctrl_pkg;
   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;
   localparam logic [1:0] ST_RESP = 2'd3;
endpackage

// File: rtl/lsu_mem_ctrl_align.sv
// lsu_mem_ctrl_align: combinational alignment check, byte mask, store replication, load extract/extend
//  size, addr_lo, unsigned_ld : access shape (size code, low address bits, zero-extend loads)
//  wdata, rdata               : right-justified store data, raw bus read word
//  misalign, wem, wdata_rep   : fault flag, byte mask, lane-replicated store data
//  rdata_ext                  : load data shifted down to bit 0 and sign/zero-extended
module lsu_mem_ctrl_align
   import lsu_mem_ctrl_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        unsigned_ld,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic        misalign,
   output logic [3:0]  wem,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata_ext
);
   logic [31:0] shifted;
   assign misalign  = size == SZ_W ? addr_lo != 2'd0 : size == SZ_H ? addr_lo[0] : size != SZ_B;
   assign wem       = size == SZ_B ? 4'b0001 << addr_lo : size == SZ_H ? 4'b0011 << addr_lo : 4'hF;
   assign wdata_rep = size == SZ_B ? {4{wdata[7:0]}} : size == SZ_H ? {2{wdata[15:0]}} : wdata;
   assign shifted   = rdata >> {addr_lo, 3'b000};
   assign rdata_ext = size == SZ_B ? {{24{~unsigned_ld & shifted[7]}}, shifted[7:0]}
                    : size == SZ_H ? {{16{~unsigned_ld & shifted[15]}}, shifted[15:0]}
                    : shifted;
endmodule

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store front-end between the memory stage and the SRAM bus
//  clk, rst                          : clock, asynchronous active-high reset
//  req_valid/ready/we/size/unsigned  : one-at-a-time core request channel
//  req_addr, req_wdata, req_tag      : byte address, right-justified store data, returned tag
//  rsp_valid/ready/rdata/tag/misalign: response channel to writeback
//  mem_req/we/size/addr/wdata/wem    : registered request to the SRAM bus
//  mem_rdata, mem_addr_ok, mem_data_ok: SRAM bus read data and handshake
module lsu_mem_ctrl
   import lsu_mem_ctrl_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32,
   parameter int MW = 4,
   parameter int TW = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic [TW-1:0] req_tag,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [DW-1:0] rsp_rdata,
   output logic [TW-1:0] rsp_tag,
   output logic          rsp_misalign,
   output logic          mem_req,
   output logic          mem_we,
   output logic [1:0]    mem_size,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic [MW-1:0] mem_wem,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_addr_ok,
   input  logic          mem_data_ok
);
   logic [1:0]    state, state_nxt;
   logic          ld_unsigned, idle, accept, capture, misalign;
   logic [MW-1:0] wem;
   logic [DW-1:0] wdata_rep, rdata_ext;
   assign idle      = state == ST_IDLE;
   assign req_ready = idle;
   assign rsp_valid = state == ST_RESP;
   assign mem_req   = state == ST_ADDR;
   assign accept    = idle && req_valid;
   assign capture   = (mem_req && mem_addr_ok && mem_data_ok) || (state == ST_DATA && mem_data_ok);
   // One aligner serves both phases: live request fields while idle, held fields once issued.
   lsu_mem_ctrl_align u_align (
      .size        (idle ? req_size : mem_size),
      .addr_lo     (idle ? req_addr[1:0] : mem_addr[1:0]),
      .unsigned_ld (idle ? req_unsigned : ld_unsigned),
      .wdata       (req_wdata),
      .rdata       (mem_rdata),
      .misalign    (misalign),
      .wem         (wem),
      .wdata_rep   (wdata_rep),
      .rdata_ext   (rdata_ext)
   );
   always_comb
      state_nxt = idle ? (req_valid ? (misalign ? ST_RESP : ST_ADDR) : ST_IDLE)
                : mem_req ? (mem_addr_ok ? (mem_data_ok ? ST_RESP : ST_DATA) : ST_ADDR)
                : state == ST_DATA ? (mem_data_ok ? ST_RESP : ST_DATA)
                : (rsp_ready ? ST_IDLE : ST_RESP);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         mem_we       <= 1'b0;
         mem_size     <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_wem      <= '0;
         rsp_tag      <= '0;
         ld_unsigned  <= 1'b0;
         rsp_rdata    <= '0;
         rsp_misalign <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            mem_we       <= req_we;
            mem_size     <= req_size;
            mem_addr     <= req_addr;
            mem_wdata    <= wdata_rep;
            mem_wem      <= req_we ? wem : '0;
            rsp_tag      <= req_tag;
            ld_unsigned  <= req_unsigned;
            rsp_rdata    <= '0;
            rsp_misalign <= misalign;
         end
         if (capture) rsp_rdata <= mem_we ? '0 : rdata_ext;
      end
   end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed scoreboard bench for the load/store front-end
module tb_lsu_mem_ctrl;
   typedef struct packed {
      logic [31:0] rd;
      logic [4:0]  tag;
      logic        mis;
   } exp_t;
   logic        clk = 1'b0, rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_tag = '0;
   logic        rsp_ready = 1'b0, mem_addr_ok = 1'b0, mem_data_ok = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        req_ready, rsp_valid, rsp_misalign, mem_req, mem_we;
   logic [31:0] rsp_rdata, mem_addr, mem_wdata;
   logic [4:0]  rsp_tag;
   logic [1:0]  mem_size;
   logic [3:0]  mem_wem;
   exp_t        sb_q[$];
   int          checks = 0, errors = 0;

   lsu_mem_ctrl dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_tag(req_tag), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_tag(rsp_tag), .rsp_misalign(rsp_misalign), .mem_req(mem_req), .mem_we(mem_we),
      .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wem(mem_wem),
      .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Monitor: consumes one expected response per completed handshake.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) chk("sb_unexpected_rsp", 32'(sb_q.size()), 1);
         else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            chk("rsp_misalign", 32'(rsp_misalign), 32'(e.mis));
         end
      end
   end

   task automatic run(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [4:0] tag, input logic [31:0] mword,
                      input logic [31:0] exp_rd, input logic exp_mis, input logic [3:0] exp_wem,
                      input logic [31:0] exp_wd, input int ad, input int rd, input logic same);
      sb_q.push_back('{rd: exp_rd, tag: tag, mis: exp_mis});
      chk("req_ready_idle", 32'(req_ready), 1);
      req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
      req_addr = addr; req_wdata = wd; req_tag = tag;
      tick();
      req_valid = 1'b0; req_wdata = 32'h5A5A5A5A; req_addr = 32'hFFFF_FFFF;
      if (exp_mis) begin
         chk("mis_no_mem_req", 32'(mem_req), 0);
         chk("mis_rsp_valid", 32'(rsp_valid), 1);
      end else begin
         chk("rsp_valid_early", 32'(rsp_valid), 0);
         for (int i = 0; i <= ad; i++) begin
            chk("mem_req", 32'(mem_req), 1);
            chk("mem_addr", mem_addr, addr);
            chk("mem_we", 32'(mem_we), 32'(we));
            chk("mem_size", 32'(mem_size), 32'(sz));
            chk("mem_wem", 32'(mem_wem), 32'(exp_wem));
            if (we) chk("mem_wdata", mem_wdata, exp_wd);
            chk("req_ready_busy", 32'(req_ready), 0);
            if (i < ad) begin
               mem_data_ok = 1'b1; mem_rdata = 32'hBAD0_BAD0;
               tick();
               mem_data_ok = 1'b0;
            end
         end
         mem_addr_ok = 1'b1;
         if (same) begin mem_data_ok = 1'b1; mem_rdata = mword; end
         tick();
         mem_addr_ok = 1'b0;
         if (!same) begin
            chk("data_wait_no_req", 32'(mem_req), 0);
            chk("data_wait_no_rsp", 32'(rsp_valid), 0);
            mem_rdata = mword; mem_data_ok = 1'b1;
            tick();
         end
         mem_data_ok = 1'b0; mem_rdata = 32'hBAD1_BAD1;
         chk("rsp_valid_lat", 32'(rsp_valid), 1);
      end
      for (int i = 0; i < rd; i++) begin
         mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
         tick();
         mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
         chk("rsp_hold_valid", 32'(rsp_valid), 1);
         chk("rsp_hold_rdata", rsp_rdata, exp_rd);
         chk("rsp_hold_tag", 32'(rsp_tag), 32'(tag));
         chk("rsp_hold_req_ready", 32'(req_ready), 0);
         chk("rsp_hold_no_mem_req", 32'(mem_req), 0);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk("rsp_done", 32'(rsp_valid), 0);
   endtask

   initial begin
      #3;
      chk("rst_req_ready", 32'(req_ready), 1);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_mem_req", 32'(mem_req), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wem", 32'(mem_wem), 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_rsp_tag", 32'(rsp_tag), 0);
      tick();
      rst = 1'b0;
      tick();
      //   we   sz    uns   addr          wdata         tag    mem word      expected      mis   wem      exp wdata     ad rd same
      run(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0,        5'd1,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0,        5'd2,  32'h80FF0000, 32'hFFFFFF80, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0,        5'd3,  32'h80FF0000, 32'h00000080, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0,        5'd4,  32'h80FF0000, 32'hFFFF80FF, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0,        5'd5,  32'h80FF0000, 32'h000080FF, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd0, 1'b0, 32'h0000_0101, 32'h0,        5'd6,  32'h00007F00, 32'h0000007F, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h123456AB, 5'd7,  32'hFFFFFFFF, 32'h00000000, 1'b0, 4'b0010, 32'hABABABAB, 0, 0, 1'b0);
      run(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h123456AB, 5'd8,  32'hFFFFFFFF, 32'h00000000, 1'b0, 4'b1100, 32'h56AB56AB, 0, 0, 1'b0);
      run(1'b1, 2'd2, 1'b0, 32'h0000_0204, 32'hCAFEBABE, 5'd9,  32'hFFFFFFFF, 32'h00000000, 1'b0, 4'hF,    32'hCAFEBABE, 0, 0, 1'b1);
      run(1'b0, 2'd2, 1'b0, 32'h0000_0102, 32'h0,        5'd10, 32'h0,        32'h00000000, 1'b1, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd3, 1'b0, 32'h0000_0100, 32'h0,        5'd11, 32'h0,        32'h00000000, 1'b1, 4'h0,    32'h0,        0, 1, 1'b0);
      run(1'b1, 2'd1, 1'b0, 32'h0000_0101, 32'h1111,     5'd12, 32'h0,        32'h00000000, 1'b1, 4'h0,    32'h0,        0, 0, 1'b0);
      run(1'b0, 2'd2, 1'b0, 32'h0000_0104, 32'h0,        5'd13, 32'h11223344, 32'h11223344, 1'b0, 4'h0,    32'h0,        3, 2, 1'b0);
      run(1'b0, 2'd2, 1'b0, 32'h0000_0108, 32'h0,        5'd14, 32'h55667788, 32'h55667788, 1'b0, 4'h0,    32'h0,        0, 0, 1'b1);
      // Reset while waiting for data: everything returns to reset values without a clock edge.
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10C; req_tag = 5'd20;
      tick();
      req_valid = 1'b0; mem_addr_ok = 1'b1;
      tick();
      mem_addr_ok = 1'b0;
      chk("pre_rst_req_ready", 32'(req_ready), 0);
      rst = 1'b1;
      #1;
      chk("mid_rst_mem_req", 32'(mem_req), 0);
      chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
      chk("mid_rst_req_ready", 32'(req_ready), 1);
      chk("mid_rst_mem_addr", mem_addr, 0);
      tick();
      rst = 1'b0;
      tick();
      run(1'b0, 2'd2, 1'b0, 32'h0000_0110, 32'h0,        5'd21, 32'h0BADF00D, 32'h0BADF00D, 1'b0, 4'h0,    32'h0,        0, 0, 1'b0);
      tick();
      chk("sb_drain", 32'(sb_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
